// File: rtl/pacman_pkg.sv
// Shared types and helpers for the player/ghost direction logic.
package pacman_pkg;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_LEFT  = 3'd1,
      DIR_RIGHT = 3'd2,
      DIR_DOWN  = 3'd3,
      DIR_UP    = 3'd4
   } dir_t;

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_W = 8'h1A;

   function automatic dir_t key_to_dir(input logic [7:0] key);
      dir_t d;
      case (key)
         KEY_A:   d = DIR_LEFT;
         KEY_D:   d = DIR_RIGHT;
         KEY_S:   d = DIR_DOWN;
         KEY_W:   d = DIR_UP;
         default: d = DIR_NONE;
      endcase
      return d;
   endfunction

   // Maze mask layout: [3] up, [2] down, [1] right, [0] left. NONE is never open.
   function automatic logic dir_open(input logic [3:0] mask, input dir_t dir);
      logic o;
      case (dir)
         DIR_LEFT:  o = mask[0];
         DIR_RIGHT: o = mask[1];
         DIR_DOWN:  o = mask[2];
         DIR_UP:    o = mask[3];
         default:   o = 1'b0;
      endcase
      return o;
   endfunction

   function automatic dir_t dir_opposite(input dir_t dir);
      dir_t o;
      case (dir)
         DIR_LEFT:  o = DIR_RIGHT;
         DIR_RIGHT: o = DIR_LEFT;
         DIR_DOWN:  o = DIR_UP;
         DIR_UP:    o = DIR_DOWN;
         default:   o = DIR_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-rate keycode debouncer: one accept pulse per stable WASD press.
module key_debounce
   import pacman_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   output logic       accept,
   output dir_t       acc_dir
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE);

   logic [7:0] last_code_q, last_code_d;
   logic [3:0] cnt_q, cnt_d;
   logic       is_dir;

   // Stability count; accept fires only on the tick the count reaches DEB,
   // so a saturated (held) key never fires again.
   always_comb begin
      acc_dir     = key_to_dir(keycode);
      is_dir      = (acc_dir != DIR_NONE);
      last_code_d = last_code_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      if (frame_tick) begin
         if (is_dir && (keycode == last_code_q)) begin
            if (cnt_q != DEB) begin
               cnt_d  = cnt_q + 4'd1;
               accept = ((cnt_q + 4'd1) == DEB);
            end
         end else begin
            last_code_d = keycode;
            cnt_d       = is_dir ? 4'd1 : 4'd0;
            accept      = is_dir && (DEB == 4'd1);
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         last_code_q <= 8'h00;
         cnt_q       <= 4'd0;
      end else begin
         last_code_q <= last_code_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: rtl/pac_dir_ctrl.sv
// Player direction control: debounced key requests, pre-turn buffering,
// blocked-direction stop and per-frame motion step decode.
module pac_dir_ctrl
   import pacman_pkg::*;
#(
   parameter logic [9:0]  STEP        = 10'd1,
   parameter int unsigned DEBOUNCE    = 2,
   parameter int unsigned HOLD_FRAMES = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic [3:0] open_mask,
   output dir_t       cur_dir,
   output logic       pend_valid,
   output dir_t       pend_dir,
   output logic [9:0] X_Motion,
   output logic [9:0] Y_Motion
);

   // timer_q holds the ticks a blocked request still has left after the
   // current one, so the accept tick itself counts toward HOLD_FRAMES.
   localparam logic [7:0] HOLD_M1 = 8'(HOLD_FRAMES - 1);

   logic       accept;
   dir_t       acc_dir;
   dir_t       cur_dir_q, cur_dir_d;
   dir_t       pend_dir_q, pend_dir_d;
   logic       pend_valid_q, pend_valid_d;
   logic [7:0] timer_q, timer_d;
   dir_t       req;
   logic       req_v;
   logic       applied;

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_debounce (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .accept     (accept),
      .acc_dir    (acc_dir)
   );

   // Request resolution, apply/hold decision and blocked-direction stop.
   always_comb begin
      cur_dir_d    = cur_dir_q;
      pend_dir_d   = pend_dir_q;
      pend_valid_d = pend_valid_q;
      timer_d      = timer_q;
      req          = accept ? acc_dir : pend_dir_q;
      req_v        = accept | pend_valid_q;
      applied      = req_v && dir_open(open_mask, req);
      if (frame_tick) begin
         if (applied) begin
            cur_dir_d    = req;
            pend_valid_d = 1'b0;
         end else begin
            if (req_v) begin
               pend_dir_d   = req;
               timer_d      = accept ? HOLD_M1 : (timer_q - 8'd1);
               pend_valid_d = (timer_d != 8'd0);
            end
            if ((cur_dir_q != DIR_NONE) && !dir_open(open_mask, cur_dir_q))
               cur_dir_d = DIR_NONE;
         end
      end
   end

   // Direction/request state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur_dir_q    <= DIR_NONE;
         pend_dir_q   <= DIR_NONE;
         pend_valid_q <= 1'b0;
         timer_q      <= 8'd0;
      end else begin
         cur_dir_q    <= cur_dir_d;
         pend_dir_q   <= pend_dir_d;
         pend_valid_q <= pend_valid_d;
         timer_q      <= timer_d;
      end
   end

   // Motion step decode from the registered direction.
   always_comb begin
      X_Motion = 10'd0;
      Y_Motion = 10'd0;
      case (cur_dir_q)
         DIR_LEFT:  X_Motion = 10'd0 - STEP;
         DIR_RIGHT: X_Motion = STEP;
         DIR_UP:    Y_Motion = 10'd0 - STEP;
         DIR_DOWN:  Y_Motion = STEP;
         default:   ;
      endcase
   end

   assign cur_dir    = cur_dir_q;
   assign pend_dir   = pend_dir_q;
   assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Bench for pac_dir_ctrl: directed scenarios plus random key/maze traffic
// compared against a tick-level behavioural model.
module tb_pac_dir_ctrl;

   localparam int DEB  = 2;
   localparam int HOLD = 16;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic [7:0] keycode;
   logic [3:0] open_mask;
   logic [2:0] cur_dir;
   logic       pend_valid;
   logic [2:0] pend_dir;
   logic [9:0] X_Motion;
   logic [9:0] Y_Motion;

   pac_dir_ctrl #(.STEP(10'd1), .DEBOUNCE(DEB), .HOLD_FRAMES(HOLD)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .open_mask  (open_mask),
      .cur_dir    (cur_dir),
      .pend_valid (pend_valid),
      .pend_dir   (pend_dir),
      .X_Motion   (X_Motion),
      .Y_Motion   (Y_Motion)
   );

   always #5 Clk = ~Clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: unbounded hold count, pending request as an absolute
   // deadline tick number.
   int m_prev_key, m_held, m_cur, m_pvalid, m_pdir, m_deadline, m_tick;

   function automatic int key_dir(input int k);
      case (k)
         'h04:    return 1;
         'h07:    return 2;
         'h16:    return 3;
         'h1A:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_open(input logic [3:0] m, input int d);
      case (d)
         1:       return m[0];
         2:       return m[1];
         3:       return m[2];
         4:       return m[3];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [9:0] exp_x(input int c);
      return (c == 1) ? 10'h3FF : (c == 2) ? 10'h001 : 10'h000;
   endfunction

   function automatic logic [9:0] exp_y(input int c);
      return (c == 4) ? 10'h3FF : (c == 3) ? 10'h001 : 10'h000;
   endfunction

   task automatic model_reset();
      m_prev_key = 0; m_held = 0; m_cur = 0; m_pvalid = 0;
      m_pdir = 0; m_deadline = 0; m_tick = 0;
   endtask

   task automatic model_step(input int key, input logic [3:0] m);
      int kd;
      bit acc, have;
      kd = key_dir(key);
      m_tick++;
      if (kd != 0 && key == m_prev_key) m_held++;
      else m_held = (kd != 0) ? 1 : 0;
      m_prev_key = key;
      acc = (kd != 0) && (m_held == DEB);
      if (acc) begin
         m_pdir     = kd;
         m_deadline = m_tick + HOLD - 1;
      end
      have = acc || (m_pvalid != 0);
      if (have && is_open(m, m_pdir)) begin
         m_cur    = m_pdir;
         m_pvalid = 0;
      end else begin
         if (have) m_pvalid = (m_tick < m_deadline) ? 1 : 0;
         if (m_cur != 0 && !is_open(m, m_cur)) m_cur = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cur"}, cur_dir, m_cur);
      chk({tag, ".pv"}, pend_valid, m_pvalid);
      if (m_pvalid != 0) chk({tag, ".pd"}, pend_dir, m_pdir);
      chk({tag, ".x"}, X_Motion, exp_x(m_cur));
      chk({tag, ".y"}, Y_Motion, exp_y(m_cur));
   endtask

   task automatic do_tick(input logic [7:0] key, input logic [3:0] m);
      @(negedge Clk);
      keycode    = key;
      open_mask  = m;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      keycode    = 8'($urandom);
      open_mask  = 4'($urandom);
      model_step(int'(key), m);
      check_all("tick");
      repeat ($urandom_range(0, 2)) @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset      = 1'b1;
      frame_tick = 1'b1;
      keycode    = 8'h1A;
      open_mask  = 4'hF;
      @(negedge Clk);
      Reset      = 1'b0;
      frame_tick = 1'b0;
      model_reset();
      chk("rst.cur", cur_dir, 0);
      chk("rst.pv", pend_valid, 0);
      chk("rst.x", X_Motion, 0);
      chk("rst.y", Y_Motion, 0);
   endtask

   logic [7:0] key_tbl [6];
   logic [7:0] r_key;
   logic [3:0] r_mask;

   initial begin
      key_tbl = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h00, 8'h00};
      Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; open_mask = 4'h0;
      repeat (3) @(negedge Clk);
      do_reset();
      chk("rst.pd", pend_dir, 0);

      // D held two ticks with right open
      do_tick(8'h07, 4'b0010);
      chk("d1.cur", cur_dir, 0);
      do_tick(8'h07, 4'b0010);
      chk("d2.cur", cur_dir, 2);
      chk("d2.x", X_Motion, 10'd1);
      repeat (10) do_tick(8'h07, 4'b0001);
      chk("dhold.pv", pend_valid, 0);
      chk("dhold.cur", cur_dir, 0);

      // Pre-turn to up, opening on the 5th tick after accept
      do_tick(8'h00, 4'b0010);
      do_tick(8'h07, 4'b0010);
      do_tick(8'h07, 4'b0010);
      do_tick(8'h1A, 4'b0010);
      do_tick(8'h1A, 4'b0010);
      chk("pre.pv", pend_valid, 1);
      chk("pre.pd", pend_dir, 4);
      chk("pre.cur", cur_dir, 2);
      repeat (4) do_tick(8'h00, 4'b0010);
      chk("pre4.pv", pend_valid, 1);
      do_tick(8'h00, 4'b1010);
      chk("turn.cur", cur_dir, 4);
      chk("turn.y", Y_Motion, 10'h3FF);
      chk("turn.pv", pend_valid, 0);

      // Hold expiry with up never open
      do_tick(8'h00, 4'b0000);
      do_tick(8'h1A, 4'b0000);
      do_tick(8'h1A, 4'b0000);
      repeat (14) do_tick(8'h00, 4'b0000);
      chk("hold15.pv", pend_valid, 1);
      do_tick(8'h00, 4'b0000);
      chk("hold16.pv", pend_valid, 0);
      chk("hold16.cur", cur_dir, 0);

      // Left then blocked with no request
      do_tick(8'h00, 4'b0001);
      do_tick(8'h04, 4'b0001);
      do_tick(8'h04, 4'b0001);
      chk("left.x", X_Motion, 10'h3FF);
      do_tick(8'h00, 4'b1110);
      chk("stop.cur", cur_dir, 0);
      chk("stop.x", X_Motion, 0);
      chk("stop.y", Y_Motion, 0);

      // Glitching and stuck-at-zero keys never accept
      for (int i = 0; i < 8; i++) do_tick((i % 2 != 0) ? 8'h07 : 8'h04, 4'b1111);
      chk("glitch.cur", cur_dir, 0);
      chk("glitch.pv", pend_valid, 0);
      do_tick(8'h04, 4'b1111);
      repeat (5) do_tick(8'h00, 4'b1111);
      chk("stuck.cur", cur_dir, 0);
      chk("stuck.pv", pend_valid, 0);

      // Reset while moving up with a blocked request pending
      do_tick(8'h00, 4'b1000);
      do_tick(8'h1A, 4'b1000);
      do_tick(8'h1A, 4'b1000);
      do_tick(8'h07, 4'b1000);
      do_tick(8'h07, 4'b1000);
      chk("mid.cur", cur_dir, 4);
      chk("mid.pv", pend_valid, 1);
      do_reset();

      // Random traffic
      r_key = 8'h00;
      r_mask = 4'hF;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         if ($urandom_range(0, 9) >= 6) begin
            if ($urandom_range(0, 4) == 0) r_key = 8'($urandom);
            else r_key = key_tbl[$urandom_range(0, 5)];
         end
         if ($urandom_range(0, 3) == 0) r_mask = 4'($urandom);
         do_tick(r_key, r_mask);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
